// File: rtl/cache_line_controller_pkg.sv
// rtl/cache_line_controller_pkg.sv - shared cache geometry and miss sequencer state type
// Geometry defaults are shared with the cache datapath modules.
package cache_pkg;

  localparam int ADDR_W_DEF     = 16;
  localparam int INDEX_W_DEF    = 3;
  localparam int WORD_OFF_W_DEF = 2;

  localparam int OFFSET_BITS = WORD_OFF_W_DEF + 2;
  localparam int LINE_BYTES  = 1 << OFFSET_BITS;
  localparam int LINE_W      = ADDR_W_DEF - OFFSET_BITS;
  localparam int TAG_WIDTH   = LINE_W - INDEX_W_DEF;

  typedef enum logic [1:0] {
    ST_IDLE      = 2'd0,
    ST_WRITEBACK = 2'd1,
    ST_FILL      = 2'd2,
    ST_DONE      = 2'd3
  } miss_state_e;

  // Byte-offset width of a line holding 2**word_off_w 32-bit words.
  function automatic int offset_bits_of(input int word_off_w);
    return word_off_w + 2;
  endfunction

  function automatic int line_w_of(input int addr_w, input int word_off_w);
    return addr_w - offset_bits_of(word_off_w);
  endfunction

endpackage

// File: rtl/cache_line_controller_if.sv
// rtl/cache_line_controller_if.sv - miss request, line array and external RAM port bundle
// master = miss sequencer, slave = cache lookup / data array / RAM side.
interface cache_line_controller_if #(
  parameter int ADDR_W = cache_pkg::ADDR_W_DEF,
  parameter int OFF_W  = cache_pkg::OFFSET_BITS
) ();

  localparam int LINE_AW = ADDR_W - OFF_W;

  logic               miss_req;
  logic [LINE_AW-1:0] miss_line_addr;
  logic               victim_dirty;
  logic [LINE_AW-1:0] victim_line_addr;
  logic               busy;
  logic               done;

  logic [OFF_W-1:0]   arr_byte;
  logic [7:0]         arr_rdata;
  logic               arr_we;
  logic [7:0]         arr_wdata;

  logic [ADDR_W-1:0]  ram_address;
  logic               ram_rd;
  logic               ram_wr;
  logic [7:0]         ram_wdata;
  logic [7:0]         ram_rdata;
  logic               ram_ack;

  modport master (
    input  miss_req, miss_line_addr, victim_dirty, victim_line_addr,
    output busy, done,
    output arr_byte, arr_we, arr_wdata,
    input  arr_rdata,
    output ram_address, ram_rd, ram_wr, ram_wdata,
    input  ram_rdata, ram_ack
  );

  modport slave (
    output miss_req, miss_line_addr, victim_dirty, victim_line_addr,
    input  busy, done,
    input  arr_byte, arr_we, arr_wdata,
    output arr_rdata,
    input  ram_address, ram_rd, ram_wr, ram_wdata,
    output ram_rdata, ram_ack
  );

endinterface

// File: rtl/cache_line_controller.sv
// rtl/cache_line_controller.sv - write-back / allocate miss sequencer for the direct-mapped cache
// Streams the dirty victim out byte by byte, then fills the requested line byte by byte.
module cache_line_controller
  import cache_pkg::*;
#(
  parameter int ADDRESS_WIDTH     = 16,
  parameter int INDEX_WIDTH       = 3,
  parameter int WORD_OFFSET_WIDTH = 2
) (
  input logic                    clk,
  input logic                    rst,
  cache_line_controller_if.master bus
);

  localparam int OFF_W   = offset_bits_of(WORD_OFFSET_WIDTH);
  localparam int LINE_AW = line_w_of(ADDRESS_WIDTH, WORD_OFFSET_WIDTH);

  generate
    if (ADDRESS_WIDTH <= OFF_W + INDEX_WIDTH) begin : g_bad_geometry
      $fatal(1, "cache_line_controller: ADDRESS_WIDTH leaves no tag bits");
    end
  endgenerate

  miss_state_e        state_q, state_d;
  logic [OFF_W-1:0]   cnt_q, cnt_d;
  logic [LINE_AW-1:0] miss_line_q, miss_line_d;
  logic [LINE_AW-1:0] victim_line_q, victim_line_d;

  logic                busy, done, arr_we, ram_rd, ram_wr;
  logic [OFF_W-1:0]    arr_byte;
  logic [7:0]          arr_wdata, ram_wdata;
  logic [ADDRESS_WIDTH-1:0] ram_address;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q       <= ST_IDLE;
      cnt_q         <= '0;
      miss_line_q   <= '0;
      victim_line_q <= '0;
    end else begin
      state_q       <= state_d;
      cnt_q         <= cnt_d;
      miss_line_q   <= miss_line_d;
      victim_line_q <= victim_line_d;
    end
  end

  // Outputs are decoded straight from state so reset clears them without waiting for a clock.
  always_comb begin
    state_d       = state_q;
    cnt_d         = cnt_q;
    miss_line_d   = miss_line_q;
    victim_line_d = victim_line_q;
    busy          = 1'b0;
    done          = 1'b0;
    arr_we        = 1'b0;
    arr_wdata     = '0;
    arr_byte      = '0;
    ram_rd        = 1'b0;
    ram_wr        = 1'b0;
    ram_wdata     = '0;
    ram_address   = '0;

    case (state_q)
      ST_IDLE: begin
        if (bus.miss_req) begin
          miss_line_d   = bus.miss_line_addr;
          victim_line_d = bus.victim_line_addr;
          cnt_d         = '0;
          state_d       = bus.victim_dirty ? ST_WRITEBACK : ST_FILL;
        end
      end

      ST_WRITEBACK: begin
        busy        = 1'b1;
        ram_wr      = 1'b1;
        ram_address = {victim_line_q, cnt_q};
        arr_byte    = cnt_q;
        ram_wdata   = bus.arr_rdata;
        if (bus.ram_ack) begin
          if (&cnt_q) begin
            cnt_d   = '0;
            state_d = ST_FILL;
          end else begin
            cnt_d = cnt_q + 1'b1;
          end
        end
      end

      ST_FILL: begin
        busy        = 1'b1;
        ram_rd      = 1'b1;
        ram_address = {miss_line_q, cnt_q};
        arr_byte    = cnt_q;
        if (bus.ram_ack) begin
          arr_we    = 1'b1;
          arr_wdata = bus.ram_rdata;
          if (&cnt_q) begin
            state_d = ST_DONE;
          end else begin
            cnt_d = cnt_q + 1'b1;
          end
        end
      end

      ST_DONE: begin
        busy    = 1'b1;
        done    = 1'b1;
        state_d = ST_IDLE;
      end

      default: state_d = ST_IDLE;
    endcase
  end

  assign bus.busy        = busy;
  assign bus.done        = done;
  assign bus.arr_we      = arr_we;
  assign bus.arr_wdata   = arr_wdata;
  assign bus.arr_byte    = arr_byte;
  assign bus.ram_rd      = ram_rd;
  assign bus.ram_wr      = ram_wr;
  assign bus.ram_wdata   = ram_wdata;
  assign bus.ram_address = ram_address;

endmodule

// File: tb/tb_cache_line_controller.sv
// tb/tb_cache_line_controller.sv - scoreboard bench for cache_line_controller
module tb_cache_line_controller;

  typedef struct {
    int         kind;    // 0 write-back byte, 1 fill byte, 2 done pulse
    logic [15:0] addr;
    logic [7:0]  data;
    logic [3:0]  byte_i;
  } exp_t;

  logic clk;
  logic rst;
  int   ack_mode;
  int   cyc;
  int   passed;
  int   total;
  int   we_count;

  logic [7:0] line_data [16];
  logic [7:0] ram_mem   [65536];
  logic [7:0] ref_mem   [65536];
  exp_t       sbq[$];

  logic        prev_pend;
  logic [25:0] prev_bus;

  cache_line_controller_if #(.ADDR_W(16), .OFF_W(4)) bus ();

  cache_line_controller #(
    .ADDRESS_WIDTH(16),
    .INDEX_WIDTH(3),
    .WORD_OFFSET_WIDTH(2)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  assign bus.arr_rdata = line_data[bus.arr_byte];
  assign bus.ram_rdata = ram_mem[bus.ram_address];

  always @(posedge clk)
    if (rst && bus.ram_ack && bus.ram_wr) ram_mem[bus.ram_address] <= bus.ram_wdata;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act === exp) passed++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
  endtask

  function automatic logic [63:0] all_outputs();
    return {23'd0, bus.busy, bus.done, bus.arr_we, bus.ram_rd, bus.ram_wr,
            bus.ram_address, bus.ram_wdata, bus.arr_byte, bus.arr_wdata};
  endfunction

  initial begin
    ack_mode    = 0;
    cyc         = 0;
    bus.ram_ack = 1'b1;
    forever begin
      @(posedge clk);
      #1;
      cyc++;
      case (ack_mode)
        0:       bus.ram_ack = 1'b1;
        1:       bus.ram_ack = (cyc % 3 == 0);
        default: bus.ram_ack = 1'($urandom_range(0, 1));
      endcase
    end
  end

  always @(negedge clk) begin
    if (!rst) begin
      prev_pend = 1'b0;
    end else begin
      exp_t e;
      int   kind;
      chk("rd_wr_exclusive", {bus.ram_rd, bus.ram_wr} == 2'b11, 0);
      chk("arr_we_only_on_fill_ack", bus.arr_we, bus.ram_ack && bus.ram_rd);
      if (prev_pend)
        chk("hold_during_wait", {bus.ram_rd, bus.ram_wr, bus.ram_address, bus.ram_wdata}, prev_bus);
      prev_pend = (bus.ram_rd || bus.ram_wr) && !bus.ram_ack;
      prev_bus  = {bus.ram_rd, bus.ram_wr, bus.ram_address, bus.ram_wdata};
      if (bus.arr_we) we_count++;
      if ((bus.ram_ack && (bus.ram_rd || bus.ram_wr)) || bus.done) begin
        kind = bus.ram_wr ? 0 : (bus.ram_rd ? 1 : 2);
        if (sbq.size() == 0) begin
          chk("unexpected_event", kind + 1, 0);
        end else begin
          e = sbq.pop_front();
          chk("event_kind", kind, e.kind);
          if (e.kind == 0) begin
            chk("wb_address", bus.ram_address, e.addr);
            chk("wb_data", bus.ram_wdata, e.data);
            chk("wb_arr_byte", bus.arr_byte, e.byte_i);
          end else if (e.kind == 1) begin
            chk("fill_address", bus.ram_address, e.addr);
            chk("fill_data", bus.arr_wdata, e.data);
            chk("fill_arr_byte", bus.arr_byte, e.byte_i);
          end
        end
      end
    end
  end

  task automatic push_exp(input logic [11:0] line, input logic [11:0] victim, input logic dirty);
    exp_t e;
    if (dirty) begin
      for (int k = 0; k < 16; k++) begin
        e.kind = 0; e.addr = victim * 16 + k; e.data = line_data[k]; e.byte_i = 4'(k);
        sbq.push_back(e);
        ref_mem[e.addr] = line_data[k];
      end
    end
    for (int k = 0; k < 16; k++) begin
      e.kind = 1; e.addr = line * 16 + k; e.data = ref_mem[e.addr]; e.byte_i = 4'(k);
      sbq.push_back(e);
    end
    e.kind = 2; e.addr = 0; e.data = 0; e.byte_i = 0;
    sbq.push_back(e);
  endtask

  // Called just after the sampling edge; returns at the negedge showing done.
  task automatic wait_done(input bit scramble, input int exp_lat);
    int lat;
    bit seen;
    lat  = 0;
    seen = 0;
    we_count = 0;
    for (int i = 0; i < 400; i++) begin
      @(negedge clk);
      lat++;
      chk("busy_while_active", bus.busy, 1);
      if (bus.done) begin
        seen = 1;
        break;
      end
      @(posedge clk);
      #1;
      if (scramble) begin
        bus.miss_req         = 1'($urandom_range(0, 1));
        bus.miss_line_addr   = 12'($urandom_range(0, 4095));
        bus.victim_line_addr = 12'($urandom_range(0, 4095));
        bus.victim_dirty     = 1'($urandom_range(0, 1));
      end
    end
    chk("done_seen", seen, 1);
    if (exp_lat > 0) chk("done_latency", lat, exp_lat);
    chk("array_writes", we_count, 16);
  endtask

  task automatic run_miss(input logic [11:0] line, input logic [11:0] victim,
                          input logic dirty, input bit scramble, input int exp_lat);
    for (int k = 0; k < 16; k++) line_data[k] = 8'($urandom);
    push_exp(line, victim, dirty);
    @(posedge clk);
    #1;
    bus.miss_req         = 1'b1;
    bus.miss_line_addr   = line;
    bus.victim_line_addr = victim;
    bus.victim_dirty     = dirty;
    @(posedge clk);
    #1;
    bus.miss_req = 1'b0;
    wait_done(scramble, exp_lat);
    @(posedge clk);
    #1;
    bus.miss_req = 1'b0;
    @(negedge clk);
    chk("busy_low_after_done", bus.busy, 0);
  endtask

  initial begin
    logic [11:0] a, v;
    int n;
    passed    = 0;
    total     = 0;
    prev_pend = 1'b0;
    prev_bus  = '0;
    for (int i = 0; i < 65536; i++) begin
      ram_mem[i] = 8'($urandom);
      ref_mem[i] = ram_mem[i];
    end
    for (int k = 0; k < 16; k++) line_data[k] = 8'($urandom);
    rst                  = 1'b0;
    bus.miss_req         = 1'b0;
    bus.miss_line_addr   = '0;
    bus.victim_line_addr = '0;
    bus.victim_dirty     = 1'b0;
    #3;
    chk("reset_outputs", all_outputs(), 0);
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b1;

    run_miss(12'h0A5, 12'($urandom_range(0, 4095)), 1'b0, 1'b0, 17);
    run_miss(12'h034, 12'h012, 1'b1, 1'b0, 33);

    ack_mode = 1;
    run_miss(12'($urandom_range(0, 4095)), 12'($urandom_range(0, 4095)), 1'b0, 1'b0, 0);
    run_miss(12'($urandom_range(0, 4095)), 12'($urandom_range(0, 4095)), 1'b1, 1'b0, 0);

    ack_mode = 2;
    for (int t = 0; t < 6; t++)
      run_miss(12'($urandom_range(0, 4095)), 12'($urandom_range(0, 4095)),
               1'($urandom_range(0, 1)), 1'b1, 0);

    // Abort during the fill of byte 7.
    ack_mode = 0;
    a = 12'($urandom_range(0, 4095));
    for (int k = 0; k < 16; k++) line_data[k] = 8'($urandom);
    push_exp(a, 12'h000, 1'b0);
    @(posedge clk);
    #1;
    bus.miss_req       = 1'b1;
    bus.miss_line_addr = a;
    bus.victim_dirty   = 1'b0;
    @(posedge clk);
    #1;
    bus.miss_req = 1'b0;
    n = 0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (bus.ram_rd && bus.arr_byte == 4'd7) begin
        n = 1;
        break;
      end
    end
    chk("reached_fill_byte7", n, 1);
    #2;
    rst = 1'b0;
    #1;
    chk("async_reset_outputs", all_outputs(), 0);
    sbq.delete();
    @(posedge clk);
    #1;
    chk("reset_held_outputs", all_outputs(), 0);
    @(posedge clk);
    #1;
    rst = 1'b1;
    repeat (4) begin
      @(negedge clk);
      chk("idle_after_abort", {bus.busy, bus.done}, 0);
    end

    // miss_req held across DONE restarts after a single idle cycle.
    a = 12'($urandom_range(0, 4095));
    v = 12'($urandom_range(0, 4095));
    for (int k = 0; k < 16; k++) line_data[k] = 8'($urandom);
    push_exp(a, v, 1'b1);
    @(posedge clk);
    #1;
    bus.miss_req         = 1'b1;
    bus.miss_line_addr   = a;
    bus.victim_line_addr = v;
    bus.victim_dirty     = 1'b1;
    @(posedge clk);
    #1;
    wait_done(1'b0, 33);
    push_exp(a, v, 1'b1);
    @(negedge clk);
    chk("single_idle_gap", bus.busy, 0);
    @(posedge clk);
    #1;
    bus.miss_req = 1'b0;
    wait_done(1'b0, 33);
    @(negedge clk);
    chk("busy_low_after_second", bus.busy, 0);

    ack_mode = 2;
    for (int t = 0; t < 3; t++)
      run_miss(12'($urandom_range(0, 4095)), 12'($urandom_range(0, 4095)),
               1'($urandom_range(0, 1)), 1'b0, 0);

    repeat (5) @(negedge clk);
    chk("scoreboard_drained", sbq.size(), 0);
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
